// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encoding and
// default fill / no-op values.
// Imported by mem_responder and its storage sub-module.
package mem_responder_pkg;

  // Power-up sequence: walk-clear the array, optionally stream a program in,
  // then run until the next reset.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [7:0] DEF_INIT_VAL = 8'h00;
  localparam logic [7:0] DEF_NOP_VAL  = 8'h00;

endpackage

// File: rtl/mem_responder_mem_array_2r1w.sv
// Purpose: DEPTH x DATA_W storage with two combinational read ports and one
//   synchronous write port. Latency: reads 0 cycles, write visible next cycle.
// Backpressure: none; a write is performed on every edge with we_i=1.
// Ports: clk; we_i/waddr_i/wdata_i write port; raddr_a_i/rdata_a_o and
//   raddr_b_i/rdata_b_o read ports. No reset: contents are set by the owner.
module mem_array_2r1w #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write to the read
  // address returns old data.
  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/mem_responder.sv
// Purpose: memory-side responder for a dual-port CPU memory; clears the array,
//   optionally loads a program byte stream, then serves fetch (A) and data (B).
// Latency: reads combinational; writes visible the cycle after the edge.
// Backpressure: load_ready is high only in LOAD; the stream stalls otherwise.
// Ports: clk/rst (sync, active-low); addr_a/instr_out fetch port;
//   addr_b/we_b/write_data_b/data_out_b data port; load_en/load_valid/
//   load_data/load_last/load_ready load stream; mem_ready, load_count status.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(DEF_INIT_VAL),
  parameter logic [DATA_W-1:0] NOP_VAL  = DATA_W'(DEF_NOP_VAL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] instr_out,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              we_b,
  input  logic [DATA_W-1:0] write_data_b,
  output logic [DATA_W-1:0] data_out_b,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              mem_ready,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_a, rd_b;

  // Next state plus the single write-port mux: the state alone decides who
  // owns the write port, so CLEAR/LOAD never contend with port B.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = ptr_q;
    wr_data = INIT_VAL;
    case (state_q)
      ST_CLEAR: begin
        wr_en = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d = load_en ? ST_LOAD : ST_RUN;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          wr_en   = 1'b1;
          wr_data = load_data;
          ptr_d   = ptr_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
          // Filling the last word ends the load even without load_last.
          if (load_last || ptr_q == LAST_ADDR) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        wr_en   = we_b;
        wr_addr = addr_b;
        wr_data = write_data_b;
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  mem_array_2r1w #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk       (clk),
    .we_i      (wr_en),
    .waddr_i   (wr_addr),
    .wdata_i   (wr_data),
    .raddr_a_i (addr_a),
    .rdata_a_o (rd_a),
    .raddr_b_i (addr_b),
    .rdata_b_o (rd_b)
  );

  assign mem_ready  = (state_q == ST_RUN);
  assign load_ready = (state_q == ST_LOAD);
  assign load_count = cnt_q;
  assign instr_out  = mem_ready ? rd_a : NOP_VAL;
  assign data_out_b = mem_ready ? rd_b : '0;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr_a, addr_b, write_data_b, load_data;
  logic       we_b, load_en, load_valid, load_last;
  logic [7:0] instr_out, data_out_b;
  logic       load_ready, mem_ready;
  logic [8:0] load_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .addr_a       (addr_a),
    .instr_out    (instr_out),
    .addr_b       (addr_b),
    .we_b         (we_b),
    .write_data_b (write_data_b),
    .data_out_b   (data_out_b),
    .load_en      (load_en),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .mem_ready    (mem_ready),
    .load_count   (load_count)
  );

  typedef struct {
    int         tag;
    logic [7:0] a_addr;
    logic [7:0] b_addr;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } rd_vec_t;

  rd_vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reads(input int tag);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].tag == tag) begin
        addr_a = vecs[i].a_addr;
        addr_b = vecs[i].b_addr;
        #1;
        check($sformatf("t%0d_instr@%0h", tag, vecs[i].a_addr), instr_out, vecs[i].exp_a);
        check($sformatf("t%0d_data@%0h", tag, vecs[i].b_addr), data_out_b, vecs[i].exp_b);
      end
    end
  endtask

  // Hold reset for n edges, check the reset outputs, then release.
  task automatic do_reset(input int n, input logic len);
    rst = 1'b0; we_b = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_en = len; addr_a = 8'h7F; addr_b = 8'h7F;
    repeat (n) tick();
    #1;
    check("rst_mem_ready", mem_ready, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_load_count", load_count, 0);
    check("rst_instr_nop", instr_out, 8'h00);
    check("rst_data_zero", data_out_b, 8'h00);
    rst = 1'b1;
  endtask

  // Counts cycles spent in CLEAR after reset release (bounded).
  task automatic wait_clear(input string name);
    int zeros;
    zeros = 0;
    #1;
    while (!mem_ready && !load_ready && zeros < 300) begin
      zeros++;
      tick();
      #1;
    end
    check(name, zeros, 256);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1, 8'h00, 8'h7F, 8'h00, 8'h00};
    vecs[1] = '{1, 8'hFF, 8'hFF, 8'h00, 8'h00};
    vecs[2] = '{2, 8'h00, 8'h01, 8'hA1, 8'hA2};
    vecs[3] = '{2, 8'h02, 8'h03, 8'hA3, 8'h00};
    vecs[4] = '{3, 8'h10, 8'h00, 8'h4A, 8'h5A};
    vecs[5] = '{3, 8'hFF, 8'h7F, 8'hA5, 8'h25};
    vecs[6] = '{5, 8'h05, 8'h00, 8'h00, 8'h11};
    vecs[7] = '{5, 8'h01, 8'h02, 8'h12, 8'h13};
    vecs[8] = '{6, 8'h40, 8'hFF, 8'h00, 8'h00};
    vecs[9] = '{0, 8'h00, 8'h00, 8'h00, 8'h00};

    rst = 1'b0; addr_a = '0; addr_b = '0; we_b = 1'b0; write_data_b = '0;
    load_en = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;

    // Boot once, then fill the whole array with FF through port B.
    do_reset(2, 1'b0);
    wait_clear("boot_clear_cycles");
    for (int i = 0; i < 256; i++) begin
      addr_b = 8'(i); we_b = 1'b1; write_data_b = 8'hFF;
      tick();
    end
    we_b = 1'b0; addr_b = 8'h7F;
    #1;
    check("preload_ff", data_out_b, 8'hFF);

    // Test 1: reset with load_en=0 clears everything in 256 cycles.
    do_reset(2, 1'b0);
    wait_clear("t1_clear_cycles");
    check("t1_mem_ready", mem_ready, 1);
    check("t1_load_ready", load_ready, 0);
    check("t1_load_count", load_count, 0);
    apply_reads(1);

    // Test 2: three-byte load with a bubble, load_last on the third.
    do_reset(2, 1'b1);
    wait_clear("t2_clear_cycles");
    check("t2_in_load", load_ready, 1);
    load_valid = 1'b1; load_data = 8'hA1;
    tick();
    load_valid = 1'b0;
    #1;
    check("t2_count_after_first", load_count, 1);
    tick();
    load_valid = 1'b1; load_data = 8'hA2;
    tick();
    load_data = 8'hA3; load_last = 1'b1;
    #1;
    check("t2_not_ready_before_last", mem_ready, 0);
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    #1;
    check("t2_mem_ready_after_last", mem_ready, 1);
    check("t2_load_ready_off", load_ready, 0);
    check("t2_load_count", load_count, 3);
    apply_reads(2);

    // Test 3: full 256-byte load with load_last never asserted.
    do_reset(2, 1'b1);
    wait_clear("t3_clear_cycles");
    for (int i = 0; i < 256; i++) begin
      load_valid = 1'b1; load_data = 8'(i) ^ 8'h5A;
      if (i == 255) begin
        #1;
        check("t3_count_before_last", load_count, 255);
        check("t3_still_loading", mem_ready, 0);
      end
      tick();
    end
    load_valid = 1'b0;
    #1;
    check("t3_mem_ready", mem_ready, 1);
    check("t3_load_count", load_count, 256);
    apply_reads(3);

    // Test 4: same-address write/read on both ports in RUN.
    addr_a = 8'h20; addr_b = 8'h20; we_b = 1'b1; write_data_b = 8'h3C;
    #1;
    check("t4_instr_old", instr_out, 8'h7A);
    check("t4_data_old", data_out_b, 8'h7A);
    tick();
    we_b = 1'b0;
    #1;
    check("t4_instr_new", instr_out, 8'h3C);
    check("t4_data_new", data_out_b, 8'h3C);

    // Test 5: port B writes are ignored during LOAD; outputs masked.
    do_reset(2, 1'b1);
    wait_clear("t5_clear_cycles");
    we_b = 1'b1; addr_b = 8'h05; write_data_b = 8'h99;
    load_valid = 1'b1; load_data = 8'h11;
    tick();
    load_valid = 1'b0; addr_a = 8'h00; addr_b = 8'h00;
    #1;
    check("t5_instr_nop", instr_out, 8'h00);
    check("t5_data_zero", data_out_b, 8'h00);
    tick();
    addr_b = 8'h05;
    load_valid = 1'b1; load_data = 8'h12;
    tick();
    load_data = 8'h13; load_last = 1'b1;
    tick();
    we_b = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    #1;
    check("t5_mem_ready", mem_ready, 1);
    check("t5_load_count", load_count, 3);
    apply_reads(5);

    // Test 6: one-cycle reset pulse in RUN reruns CLEAR.
    addr_b = 8'h40; we_b = 1'b1; write_data_b = 8'h77;
    tick();
    we_b = 1'b0;
    #1;
    check("t6_written", data_out_b, 8'h77);
    rst = 1'b0;
    #1;
    check("t6_ready_before_edge", mem_ready, 1);
    do_reset(1, 1'b0);
    wait_clear("t6_clear_cycles");
    check("t6_mem_ready", mem_ready, 1);
    apply_reads(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
